// File: rtl/mul_accumulator.sv
// mul_accumulator: sums up to LEN unsigned products per block and emits sum, beat count and wrap flag
module mul_accumulator #(
  parameter int PROD_W = 9,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);
  typedef enum logic {ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d, cnt_inc;
  logic ovf_q, ovf_d, oovf_q, oovf_d, novf, accept, close;
  logic [ACC_W:0] nsum;
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = oovf_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    accept  = in_valid & in_ready;
    nsum    = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    novf    = ovf_q | nsum[ACC_W];
    cnt_inc = cnt_q + CNT_W'(1);
    close   = in_last | (cnt_inc == CNT_W'(LEN));
    if (state_q == ACC && accept) begin
      if (close) begin
        state_d = OUT;
        sum_d   = nsum[ACC_W-1:0];
        count_d = cnt_inc;
        oovf_d  = novf;
      end else begin
        acc_d = nsum[ACC_W-1:0];
        cnt_d = cnt_inc;
        ovf_d = novf;
      end
    end else if (state_q == OUT && out_ready) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: directed vectors on a default instance and a narrow/long instance
module tb_mul_accumulator;
  logic clk = 1'b0;
  logic rst;
  logic in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [8:0] in_prod_a;
  logic [15:0] out_sum_a;
  logic [2:0] out_count_a;
  logic in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [8:0] in_prod_b;
  logic [9:0] out_sum_b;
  logic [3:0] out_count_b;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mul_accumulator dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_prod(in_prod_a),
    .in_last(in_last_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sum(out_sum_a),
    .out_count(out_count_a), .out_ovf(out_ovf_a)
  );
  mul_accumulator #(.ACC_W(10), .LEN(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_prod(in_prod_b),
    .in_last(in_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat_a(input logic [8:0] p, input logic l);
    in_valid_a = 1'b1;
    in_prod_a  = p;
    in_last_a  = l;
    step();
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
  endtask
  task automatic beat_b(input logic [8:0] p, input logic l);
    in_valid_b = 1'b1;
    in_prod_b  = p;
    in_last_b  = l;
    step();
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;
  endtask
  task automatic result_a(input string tag, input int sum, input int cnt, input int ovf);
    check({tag, "_valid"}, 32'(out_valid_a), 1);
    check({tag, "_ready"}, 32'(in_ready_a), 0);
    check({tag, "_sum"}, 32'(out_sum_a), sum);
    check({tag, "_count"}, 32'(out_count_a), cnt);
    check({tag, "_ovf"}, 32'(out_ovf_a), ovf);
  endtask
  initial begin
    rst = 1'b1;
    {in_valid_a, in_last_a, out_ready_a, in_valid_b, in_last_b, out_ready_b} = '0;
    in_prod_a = '0;
    in_prod_b = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_valid", 32'(out_valid_a), 0);
    check("rst_ready", 32'(in_ready_a), 1);
    check("rst_sum", 32'(out_sum_a), 0);
    check("rst_count", 32'(out_count_a), 0);
    check("rst_ovf", 32'(out_ovf_a), 0);
    out_ready_a = 1'b1;
    beat_a(143, 0);
    beat_a(15, 0);
    beat_a(225, 0);
    check("mid_block_valid", 32'(out_valid_a), 0);
    beat_a(225, 0);
    result_a("blk4", 608, 4, 0);
    step();
    check("bubble_ready", 32'(in_ready_a), 1);
    check("bubble_valid", 32'(out_valid_a), 0);
    check("held_sum", 32'(out_sum_a), 608);
    beat_a(13, 0);
    beat_a(11, 1);
    result_a("early_last", 24, 2, 0);
    step();
    beat_a(1, 0);
    beat_a(1, 0);
    beat_a(1, 0);
    beat_a(1, 0);
    result_a("ones", 4, 4, 0);
    step();
    out_ready_a = 1'b0;
    beat_a(2, 0);
    beat_a(3, 1);
    in_valid_a = 1'b1;
    in_prod_a  = 100;
    in_last_a  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      result_a("bp", 5, 2, 0);
    end
    out_ready_a = 1'b1;
    step();
    check("release_ready", 32'(in_ready_a), 1);
    check("release_valid", 32'(out_valid_a), 0);
    step();
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
    result_a("resume", 100, 1, 0);
    step();
    beat_a(3, 0);
    beat_a(5, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid_a), 0);
    check("mid_rst_ready", 32'(in_ready_a), 1);
    check("mid_rst_sum", 32'(out_sum_a), 0);
    check("mid_rst_count", 32'(out_count_a), 0);
    check("mid_rst_ovf", 32'(out_ovf_a), 0);
    beat_a(7, 0);
    beat_a(7, 0);
    beat_a(7, 0);
    beat_a(7, 1);
    result_a("after_rst", 28, 4, 0);
    step();
    check("after_rst_single_close", 32'(out_valid_a), 0);
    out_ready_b = 1'b1;
    for (int i = 0; i < 7; i++) beat_b(225, 0);
    check("b_seven_valid", 32'(out_valid_b), 0);
    beat_b(225, 0);
    check("b_wrap_valid", 32'(out_valid_b), 1);
    check("b_wrap_sum", 32'(out_sum_b), 776);
    check("b_wrap_count", 32'(out_count_b), 8);
    check("b_wrap_ovf", 32'(out_ovf_b), 1);
    step();
    beat_b(1, 0);
    beat_b(2, 1);
    check("b_next_valid", 32'(out_valid_b), 1);
    check("b_next_sum", 32'(out_sum_b), 3);
    check("b_next_count", 32'(out_count_b), 2);
    check("b_next_ovf", 32'(out_ovf_b), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
